// File: rtl/rr_output_port_ctrl.sv
// Output-port controller behind the round-robin encoder: holds a packet-long grant,
// forwards the granted input's flits through a registered valid/ready stage.
module rr_output_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_FLITS  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              rr_req_i,
  input  logic [2:0]              rr_priority_to_cs_i,
  input  logic [5*DATA_WIDTH-1:0] flit_i,
  input  logic [4:0]              valid_i,
  input  logic [4:0]              tail_i,
  output logic [4:0]              ready_o,
  output logic [DATA_WIDTH-1:0]   flit_o,
  output logic                    valid_o,
  output logic                    tail_o,
  output logic [2:0]              src_o,
  input  logic                    ready_i,
  output logic                    rr_change_order_o,
  output logic                    busy_o,
  output logic                    err_o
);

  // state | meaning
  // IDLE  | no grant held; waiting for a request with a valid encoder select
  // XFER  | grant held; forwarding flits of the granted port until tail or MAX_FLITS
  typedef enum logic {IDLE, XFER} state_t;

  localparam int CNT_W = $clog2(MAX_FLITS + 1);

  state_t                state_q, state_d;
  logic [2:0]            grant_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            port_idx;
  logic                  sel_ok;
  logic                  grant_load;
  logic                  accept;
  logic                  pkt_release;
  logic                  force_rel;
  logic [DATA_WIDTH-1:0] in_flit;
  logic                  in_valid;
  logic                  in_tail;

  // Encoder value g addresses request bit 4-g.
  assign port_idx = 3'd4 - grant_q;
  assign sel_ok   = (rr_priority_to_cs_i <= 3'd4);
  assign busy_o   = (state_q == XFER);

  always_comb begin
    in_flit  = '0;
    in_valid = 1'b0;
    in_tail  = 1'b0;
    for (int p = 0; p < 5; p++) begin
      if (port_idx == 3'(p)) begin
        in_flit  = flit_i[p*DATA_WIDTH +: DATA_WIDTH];
        in_valid = valid_i[p];
        in_tail  = tail_i[p];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_load  = 1'b0;
    accept      = 1'b0;
    pkt_release = 1'b0;
    force_rel   = 1'b0;
    ready_o     = '0;
    case (state_q)
      IDLE: begin
        if ((|rr_req_i) && sel_ok) begin
          grant_load = 1'b1;
          state_d    = XFER;
        end
      end
      XFER: begin
        accept = in_valid & (~valid_o | ready_i);
        if (accept) begin
          ready_o = 5'b00001 << port_idx;
          if (in_tail) begin
            pkt_release = 1'b1;
            state_d     = IDLE;
          end else if (cnt_q == CNT_W'(MAX_FLITS - 1)) begin
            pkt_release = 1'b1;
            force_rel   = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      cnt_q   <= '0;
    end else if (grant_load) begin
      grant_q <= rr_priority_to_cs_i;
      cnt_q   <= '0;
    end else if (accept) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Output stage: reload on accept, drop when consumed with nothing behind it, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_o  <= '0;
      valid_o <= 1'b0;
      tail_o  <= 1'b0;
      src_o   <= '0;
    end else if (accept) begin
      flit_o  <= in_flit;
      valid_o <= 1'b1;
      tail_o  <= in_tail;
      src_o   <= grant_q;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_change_order_o <= 1'b0;
      err_o             <= 1'b0;
    end else begin
      rr_change_order_o <= pkt_release;
      err_o             <= err_o | force_rel;
    end
  end

endmodule

// File: tb/tb_rr_output_port_ctrl.sv
// Bench for rr_output_port_ctrl: per-port source queues, packet-level reference model,
// per-cycle compare plus directed literal checks.
module tb_rr_output_port_ctrl;
  localparam int DW = 32;
  localparam int MF = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4:0]      rr_req_i = '0;
  logic [2:0]      rr_priority_to_cs_i = 3'd7;
  logic [5*DW-1:0] flit_i = '0;
  logic [4:0]      valid_i = '0;
  logic [4:0]      tail_i = '0;
  logic [4:0]      ready_o;
  logic [DW-1:0]   flit_o;
  logic            valid_o, tail_o;
  logic [2:0]      src_o;
  logic            ready_i = 1'b1;
  logic            rr_change_order_o, busy_o, err_o;

  rr_output_port_ctrl #(.DATA_WIDTH(DW), .MAX_FLITS(MF)) dut (
    .clk(clk), .rst(rst), .rr_req_i(rr_req_i), .rr_priority_to_cs_i(rr_priority_to_cs_i),
    .flit_i(flit_i), .valid_i(valid_i), .tail_i(tail_i), .ready_o(ready_o),
    .flit_o(flit_o), .valid_o(valid_o), .tail_o(tail_o), .src_o(src_o), .ready_i(ready_i),
    .rr_change_order_o(rr_change_order_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [DW-1:0] rx[$];
  logic [DW-1:0] q_data[5][$];
  logic          q_tail[5][$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet ownership, flit count and output register contents.
  logic          m_busy = 1'b0;
  logic [2:0]    m_g = '0;
  int            m_n = 0;
  logic          m_ov = 1'b0, m_ot = 1'b0, m_pulse = 1'b0, m_err = 1'b0;
  logic [DW-1:0] m_of = '0;
  logic [2:0]    m_os = '0;
  logic [4:0]    m_take;
  logic          m_pulse_n;
  int            m_p;

  function automatic int req_bit(logic [2:0] g);
    return 4 - int'(g);
  endfunction

  function automatic logic [4:0] exp_ready();
    int p;
    if (!m_busy) return 5'b0;
    p = req_bit(m_g);
    if (valid_i[p] && (!m_ov || ready_i)) return 5'(1 << p);
    return 5'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_g = '0; m_n = 0; m_ov = 1'b0; m_ot = 1'b0;
      m_pulse = 1'b0; m_err = 1'b0; m_of = '0; m_os = '0;
    end else begin
      m_take    = exp_ready();
      m_pulse_n = 1'b0;
      m_p       = req_bit(m_g);
      if (m_take != 0) begin
        m_of = flit_i[m_p*DW +: DW];
        m_ot = tail_i[m_p];
        m_os = m_g;
        m_ov = 1'b1;
      end else if (m_ov && ready_i) begin
        m_ov = 1'b0;
      end
      if (!m_busy) begin
        if (rr_req_i != 0 && !$isunknown(rr_priority_to_cs_i) && rr_priority_to_cs_i <= 3'd4) begin
          m_busy = 1'b1;
          m_g    = rr_priority_to_cs_i;
          m_n    = 0;
        end
      end else if (m_take != 0) begin
        m_n++;
        if (tail_i[m_p] || m_n == MF) begin
          m_pulse_n = 1'b1;
          m_busy    = 1'b0;
          if (!tail_i[m_p]) m_err = 1'b1;
        end
      end
      m_pulse = m_pulse_n;
    end
  end

  always @(negedge clk) begin
    chk("ready_o", ready_o, exp_ready());
    chk("valid_o", valid_o, m_ov);
    if (m_ov) begin
      chk("flit_o", flit_o, m_of);
      chk("tail_o", tail_o, m_ot);
      chk("src_o", src_o, m_os);
    end
    chk("rr_change_order_o", rr_change_order_o, m_pulse);
    chk("busy_o", busy_o, m_busy);
    chk("err_o", err_o, m_err);
    if (valid_o && ready_i) rx.push_back(flit_o);
    if (rr_change_order_o) pulses++;
  end

  function automatic void drive();
    for (int p = 0; p < 5; p++) begin
      valid_i[p]             = (q_data[p].size() > 0);
      flit_i[p*DW +: DW]     = (q_data[p].size() > 0) ? q_data[p][0] : '0;
      tail_i[p]              = (q_tail[p].size() > 0) ? q_tail[p][0] : 1'b0;
    end
  endfunction

  task automatic tick();
    logic [4:0] rdy;
    @(negedge clk);
    rdy = ready_o;
    @(posedge clk);
    #1;
    for (int p = 0; p < 5; p++) begin
      if (rdy[p] && q_data[p].size() > 0) begin
        void'(q_data[p].pop_front());
        void'(q_tail[p].pop_front());
      end
    end
    drive();
  endtask

  task automatic push_pkt(int p, int n, bit with_tail);
    for (int i = 0; i < n; i++) begin
      q_data[p].push_back(DW'(p*256 + i));
      q_tail[p].push_back(with_tail && (i == n-1));
    end
    drive();
  endtask

  task automatic clear_queues();
    for (int p = 0; p < 5; p++) begin
      q_data[p].delete();
      q_tail[p].delete();
    end
    drive();
  endtask

  task automatic set_req(logic [4:0] r, logic [2:0] s);
    rr_req_i = r;
    rr_priority_to_cs_i = s;
  endtask

  initial begin
    #1;
    chk("rst valid_o", valid_o, 0);
    chk("rst flit_o", flit_o, 0);
    chk("rst ready_o", ready_o, 0);
    chk("rst busy_o", busy_o, 0);
    chk("rst err_o", err_o, 0);
    chk("rst rr_change", rr_change_order_o, 0);
    #11 rst = 1'b0;
    tick(); tick();

    // Invalid or absent selects keep the port idle.
    set_req(5'b00000, 3'b111); tick(); tick();
    chk("sel7 busy_o", busy_o, 0);
    chk("sel7 ready_o", ready_o, 0);
    set_req(5'b00000, 3'bxxx); tick(); tick();
    chk("selX busy_o", busy_o, 0);
    chk("selX valid_o", valid_o, 0);
    set_req(5'b10000, 3'd5); tick(); tick();
    chk("sel5 busy_o", busy_o, 0);
    set_req(5'b00000, 3'd7);

    // North, 3 flits.
    rx.delete(); pulses = 0;
    push_pkt(4, 3, 1);
    set_req(5'b10000, 3'd0); tick();
    chk("N c1 busy_o", busy_o, 1);
    set_req(5'b00000, 3'd4); tick();
    chk("N c2 valid_o", valid_o, 1);
    chk("N c2 flit_o", flit_o, 32'h400);
    chk("N c2 src_o", src_o, 0);
    tick(); tick();
    chk("N c4 tail_o", tail_o, 1);
    chk("N c4 flit_o", flit_o, 32'h402);
    chk("N c4 rr_change", rr_change_order_o, 1);
    chk("N c4 busy_o", busy_o, 0);
    tick();
    chk("N c5 rr_change", rr_change_order_o, 0);
    chk("N c5 valid_o", valid_o, 0);
    chk("N pulses", pulses, 1);
    chk("N rx count", rx.size(), 3);

    // Local, 4 flits, downstream stall in cycles 3..5.
    rx.delete(); pulses = 0;
    push_pkt(0, 4, 1);
    set_req(5'b00001, 3'd4); tick();
    set_req(5'b00000, 3'd7); tick();
    tick();
    ready_i = 1'b0; tick();
    chk("L stall ready_o", ready_o, 0);
    chk("L stall flit_o", flit_o, 32'h001);
    chk("L stall valid_o", valid_o, 1);
    tick(); tick();
    chk("L stall end flit_o", flit_o, 32'h001);
    ready_i = 1'b1;
    tick(); tick(); tick();
    chk("L rx count", rx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx.size()) chk("L rx order", rx[i], DW'(i));
    end
    chk("L pulses", pulses, 1);

    // South then West back to back.
    rx.delete(); pulses = 0;
    push_pkt(3, 2, 1);
    push_pkt(2, 2, 1);
    set_req(5'b01000, 3'd1); tick();
    set_req(5'b01100, 3'd1); tick();
    set_req(5'b01100, 3'd2); tick();
    chk("SW gap busy_o", busy_o, 0);
    chk("SW gap rr_change", rr_change_order_o, 1);
    set_req(5'b00100, 3'd2); tick();
    chk("SW W busy_o", busy_o, 1);
    set_req(5'b00000, 3'd7); tick();
    chk("SW W src_o", src_o, 2);
    chk("SW W flit_o", flit_o, 32'h200);
    tick(); tick();
    chk("SW pulses", pulses, 2);
    chk("SW rx count", rx.size(), 4);

    // East, 6 flits without tail: forced release after MF.
    rx.delete(); pulses = 0;
    push_pkt(1, 6, 0);
    set_req(5'b00010, 3'd3); tick();
    set_req(5'b00000, 3'd7);
    tick(); tick(); tick(); tick();
    chk("E force busy_o", busy_o, 0);
    chk("E force err_o", err_o, 1);
    chk("E force rr_change", rr_change_order_o, 1);
    chk("E force flit_o", flit_o, 32'h103);
    tick(); tick(); tick();
    chk("E err sticky", err_o, 1);
    chk("E valid_o", valid_o, 0);
    chk("E rx count", rx.size(), 4);
    chk("E pulses", pulses, 1);
    clear_queues();

    // Asynchronous reset mid-packet with a flit in the output register.
    pulses = 0;
    push_pkt(4, 3, 1);
    set_req(5'b10000, 3'd0); tick();
    set_req(5'b00000, 3'd7); tick(); tick();
    chk("pre-rst valid_o", valid_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst valid_o", valid_o, 0);
    chk("arst flit_o", flit_o, 0);
    chk("arst tail_o", tail_o, 0);
    chk("arst src_o", src_o, 0);
    chk("arst ready_o", ready_o, 0);
    chk("arst busy_o", busy_o, 0);
    chk("arst err_o", err_o, 0);
    chk("arst rr_change", rr_change_order_o, 0);
    clear_queues();
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick(); tick();
    chk("post-rst pulses", pulses, 0);
    chk("post-rst busy_o", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
